vc_read_scheduler: RTL and testbench

VC_READ_SCHEDULER -- requirements
Module: vc_read_scheduler

---
 rtl/vc_read_scheduler.sv | 154 +++++++++++++++
 tb/tb_vc_read_scheduler.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/vc_read_scheduler.sv
// Five-VC read scheduler: round-robin packet-level arbitration with wormhole
// locking on multi-flit packets and a downstream credit counter.
module vc_read_scheduler #(
  parameter int CREDITS = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] empty,
  input  logic [1:0] head_type,
  input  logic       out_ready,
  input  logic       credit_in,
  output logic [2:0] rr_select,
  output logic       read_en,
  output logic       locked,
  output logic [5:0] credits,
  output logic       credit_err
);

  localparam logic       IDLE = 1'b0;
  localparam logic       LOCK = 1'b1;

  localparam logic [1:0] FT_HEAD   = 2'b00;
  localparam logic [1:0] FT_BODY   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  localparam logic [2:0] VC_N = 3'd0;
  localparam logic [2:0] VC_L = 3'd4;

  localparam logic [5:0] CREDITS_MAX = 6'(CREDITS);

  // VC codes live in 0..4; adding an offset wraps modulo five.
  function automatic logic [2:0] vc_add(input logic [2:0] base, input logic [2:0] offset);
    logic [3:0] sum;
    sum = {1'b0, base} + {1'b0, offset};
    if (sum >= 4'd5) begin
      sum = sum - 4'd5;
    end else begin
      sum = sum;
    end
    return sum[2:0];
  endfunction

  logic       state_r;
  logic       state_n_s;
  logic [2:0] ptr_r;
  logic [2:0] ptr_n_s;
  logic [2:0] owner_r;
  logic [2:0] owner_n_s;
  logic [5:0] credits_r;
  logic [5:0] credits_n_s;
  logic       credit_err_r;
  logic       credit_err_n_s;

  logic [2:0] search_sel_s;
  logic [2:0] rr_select_s;
  logic       read_en_s;
  logic       is_end_flit_s;

  // Round-robin search from ptr+1; the highest offset is evaluated first so the
  // nearest non-empty VC wins. Offset 5 is ptr itself, which is also the idle value.
  always_comb begin
    search_sel_s = ptr_r;
    for (int k = 5; k >= 1; k--) begin
      search_sel_s = empty[vc_add(ptr_r, 3'(k))] ? search_sel_s : vc_add(ptr_r, 3'(k));
    end
  end

  // Grant selection and the pop strobe; reset low blocks any pop.
  always_comb begin
    rr_select_s   = (state_r == LOCK) ? owner_r : search_sel_s;
    read_en_s     = reset & ~empty[rr_select_s] & out_ready & (credits_r != 6'd0);
    is_end_flit_s = (head_type == FT_TAIL) || (head_type == FT_SINGLE);
  end

  // Packet-level state machine: a head locks its VC until a tail or single is read.
  always_comb begin
    state_n_s = state_r;
    ptr_n_s   = ptr_r;
    owner_n_s = owner_r;
    case (state_r)
      IDLE: begin
        if (read_en_s) begin
          ptr_n_s = rr_select_s;
          if (head_type == FT_HEAD) begin
            state_n_s = LOCK;
            owner_n_s = rr_select_s;
          end else begin
            state_n_s = IDLE;
          end
        end else begin
          state_n_s = IDLE;
        end
      end
      LOCK: begin
        // ptr already equals owner, so release leaves the next search at owner+1.
        if (read_en_s && is_end_flit_s) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = LOCK;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // Credit counter: a pop consumes a slot, credit_in returns one; a return that
  // would exceed the buffer depth is dropped and flagged.
  always_comb begin
    credits_n_s    = credits_r;
    credit_err_n_s = credit_err_r;
    case ({read_en_s, credit_in})
      2'b10: begin
        credits_n_s = credits_r - 6'd1;
      end
      2'b01: begin
        if (credits_r == CREDITS_MAX) begin
          credit_err_n_s = 1'b1;
        end else begin
          credits_n_s = credits_r + 6'd1;
        end
      end
      default: begin
        credits_n_s = credits_r;
      end
    endcase
  end

  // State registers; ptr resets to L so that N is searched first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      ptr_r        <= VC_L;
      owner_r      <= VC_N;
      credits_r    <= CREDITS_MAX;
      credit_err_r <= 1'b0;
    end else begin
      state_r      <= state_n_s;
      ptr_r        <= ptr_n_s;
      owner_r      <= owner_n_s;
      credits_r    <= credits_n_s;
      credit_err_r <= credit_err_n_s;
    end
  end

  assign rr_select  = rr_select_s;
  assign read_en    = read_en_s;
  assign locked     = (state_r == LOCK);
  assign credits    = credits_r;
  assign credit_err = credit_err_r;

endmodule

// File: tb/tb_vc_read_scheduler.sv
// Directed bench for vc_read_scheduler: arbitration order, wormhole locking,
// owner starvation, credit limits, overflow flag and reset mid-packet.
module tb_vc_read_scheduler;

  logic       clk;
  logic       reset;
  logic [4:0] empty;
  logic [1:0] head_type;
  logic       out_ready;
  logic       credit_in;
  logic [2:0] rr_select;
  logic       read_en;
  logic       locked;
  logic [5:0] credits;
  logic       credit_err;

  logic [4:0] empty2;
  logic [1:0] head_type2;
  logic       out_ready2;
  logic       credit_in2;
  logic [2:0] rr_select2;
  logic       read_en2;
  logic       locked2;
  logic [5:0] credits2;
  logic       credit_err2;

  int tests = 0;
  int fails = 0;

  vc_read_scheduler dut (
    .clk(clk), .reset(reset), .empty(empty), .head_type(head_type),
    .out_ready(out_ready), .credit_in(credit_in), .rr_select(rr_select),
    .read_en(read_en), .locked(locked), .credits(credits), .credit_err(credit_err)
  );

  vc_read_scheduler #(.CREDITS(2)) dut2 (
    .clk(clk), .reset(reset), .empty(empty2), .head_type(head_type2),
    .out_ready(out_ready2), .credit_in(credit_in2), .rr_select(rr_select2),
    .read_en(read_en2), .locked(locked2), .credits(credits2), .credit_err(credit_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; empty = 5'b11111; head_type = 2'b00; out_ready = 1'b0; credit_in = 1'b0;
    empty2 = 5'b11111; head_type2 = 2'b11; out_ready2 = 1'b0; credit_in2 = 1'b0;

    // In reset with work available: no pop, reset values visible.
    tick(); empty = 5'b11100; head_type = 2'b11; out_ready = 1'b1; #1;
    chk("rst_read_en", 8'(read_en), 8'd0);
    chk("rst_locked", 8'(locked), 8'd0);
    chk("rst_credits", 8'(credits), 8'd32);
    chk("rst_credit_err", 8'(credit_err), 8'd0);
    chk("rst_sel", 8'(rr_select), 8'd0);
    chk("rst_credits2", 8'(credits2), 8'd2);

    // Singles on N and S alternate; credits fall by one each read.
    out_ready = 1'b0;
    tick(); reset = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      #1;
      chk("rr_sel", 8'(rr_select), 8'(i % 2));
      chk("rr_read_en", 8'(read_en), 8'd1);
      chk("rr_credits", 8'(credits), 8'(32 - i));
    end

    // E carries head/body/body/tail while N and L wait; ptr=S so E is found first.
    tick(); empty = 5'b01010; head_type = 2'b00; #1;
    chk("lk_sel_head", 8'(rr_select), 8'd2);
    chk("lk_locked_head", 8'(locked), 8'd0);
    chk("lk_credits_head", 8'(credits), 8'd28);
    tick(); head_type = 2'b01; #1;
    chk("lk_sel_b1", 8'(rr_select), 8'd2);
    chk("lk_locked_b1", 8'(locked), 8'd1);
    tick(); head_type = 2'b01; #1;
    chk("lk_sel_b2", 8'(rr_select), 8'd2);
    chk("lk_read_b2", 8'(read_en), 8'd1);
    tick(); head_type = 2'b10; #1;
    chk("lk_sel_tail", 8'(rr_select), 8'd2);
    chk("lk_locked_tail", 8'(locked), 8'd1);
    chk("lk_credits_tail", 8'(credits), 8'd25);
    tick(); head_type = 2'b11; #1;
    chk("lk_after_sel_L", 8'(rr_select), 8'd4);
    chk("lk_after_locked", 8'(locked), 8'd0);
    tick(); #1;
    chk("lk_after_sel_N", 8'(rr_select), 8'd0);
    chk("lk_after_credits", 8'(credits), 8'd23);

    // S locks, then runs dry for three cycles while N has data; refill resumes S.
    tick(); empty = 5'b11100; head_type = 2'b00; #1;
    chk("st_sel_head", 8'(rr_select), 8'd1);
    chk("st_credits", 8'(credits), 8'd22);
    for (int i = 0; i < 3; i++) begin
      tick(); empty = 5'b11110; head_type = 2'b01; #1;
      chk("st_dry_read_en", 8'(read_en), 8'd0);
      chk("st_dry_sel", 8'(rr_select), 8'd1);
      chk("st_dry_locked", 8'(locked), 8'd1);
    end
    chk("st_dry_credits", 8'(credits), 8'd21);
    tick(); empty = 5'b11100; head_type = 2'b10; #1;
    chk("st_refill_sel", 8'(rr_select), 8'd1);
    chk("st_refill_read_en", 8'(read_en), 8'd1);

    // Reset while S holds a packet: lock abandoned, credits restored, N first after.
    tick(); empty = 5'b11101; head_type = 2'b00; #1;
    chk("rl_sel_head", 8'(rr_select), 8'd1);
    chk("rl_credits", 8'(credits), 8'd20);
    tick(); head_type = 2'b01; #1;
    chk("rl_locked", 8'(locked), 8'd1);
    reset = 1'b0; #1;
    chk("rl_locked_rst", 8'(locked), 8'd0);
    chk("rl_credits_rst", 8'(credits), 8'd32);
    chk("rl_read_en_rst", 8'(read_en), 8'd0);
    empty = 5'b11100; head_type = 2'b11;
    tick(); reset = 1'b1; #1;
    chk("rl_release_sel", 8'(rr_select), 8'd0);
    chk("rl_release_read_en", 8'(read_en), 8'd1);

    // Read down to 5 credits, then a pop and a credit return together.
    repeat (27) tick();
    #1;
    chk("cr_at5", 8'(credits), 8'd5);
    credit_in = 1'b1; #1;
    chk("cr_both_read_en", 8'(read_en), 8'd1);
    tick(); out_ready = 1'b0; #1;
    chk("cr_both_hold", 8'(credits), 8'd5);
    tick(); #1;
    chk("cr_inc", 8'(credits), 8'd6);
    repeat (26) tick();
    #1;
    chk("cr_full", 8'(credits), 8'd32);
    chk("cr_err_before", 8'(credit_err), 8'd0);
    tick(); credit_in = 1'b0; #1;
    chk("cr_over_credits", 8'(credits), 8'd32);
    chk("cr_over_err", 8'(credit_err), 8'd1);
    out_ready = 1'b1;
    tick(); out_ready = 1'b0; #1;
    chk("cr_sticky_credits", 8'(credits), 8'd31);
    chk("cr_sticky_err", 8'(credit_err), 8'd1);

    // Two-slot instance: two reads, stall at zero, one credit buys one more read.
    tick(); empty2 = 5'b11100; out_ready2 = 1'b1; #1;
    chk("c2_r1", 8'(read_en2), 8'd1);
    chk("c2_cr1", 8'(credits2), 8'd2);
    tick(); #1;
    chk("c2_r2", 8'(read_en2), 8'd1);
    tick(); #1;
    chk("c2_stall_read_en", 8'(read_en2), 8'd0);
    chk("c2_stall_credits", 8'(credits2), 8'd0);
    tick(); credit_in2 = 1'b1; #1;
    chk("c2_stall2_read_en", 8'(read_en2), 8'd0);
    tick(); credit_in2 = 1'b0; #1;
    chk("c2_one_more", 8'(read_en2), 8'd1);
    chk("c2_one_credit", 8'(credits2), 8'd1);
    tick(); #1;
    chk("c2_stop_again", 8'(read_en2), 8'd0);
    chk("c2_zero_again", 8'(credits2), 8'd0);
    chk("c2_no_err", 8'(credit_err2), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
